multdiv_ctrl: RTL and testbench
===============================

// Module: multdiv_ctrl
// PURPOSE
//   Sequencer for the multdiv unit: tracks ops moving through the always-enabled
//   pipelined multiplier latch stages and runs the iterative divider FSM.
//   Carries each op's destination register tag to completion and drives one shared
//   result-ready/exception/select interface to the writeback stage.
//   Sits between decode (ctrl_MULT/ctrl_DIV) and the multdiv datapath.
// PARAMETERS
//   MULT_STAGES  4   multiplier latch stages; mult latency in cycles
//   DIV_CYCLES   32  divider iteration cycles (>=2)
//   TAG_W        5   destination register tag width
// PORTS
//   clock           in   1      sole clock, rising edge
//   reset           in   1      asynchronous, active-high; clears all state
//   ctrl_MULT       in   1      mult request, sampled every rising edge
//   ctrl_DIV        in   1      div request, sampled every rising edge
//   operand_b_zero  in   1      divisor == 0, valid with ctrl_DIV
//   mult_overflow   in   1      overflow flag from final mult stage
//   dest_in         in   TAG_W  destination tag of requested op
//   stall           out  1      comb: request present this cycle but not accepted
//   div_load        out  1      comb: load divider operands (div accepted this cycle)
//   div_step_en     out  1      reg: divider iterates this cycle
//   data_resultRDY  out  1      reg: result valid this cycle (1-cycle pulse per op)
//   data_exception  out  1      reg: exception on current result
//   result_sel      out  1      reg: 0 = mult result, 1 = div result
//   dest_out        out  TAG_W  reg: tag of current result
//   busy            out  1      reg: any op in flight
// BEHAVIOUR
//   - Reset: valid pipe, tag pipe, counter, FSM -> 0/IDLE; all reg outputs 0.
//     In-flight ops are dropped; no resultRDY is issued for them.
//   - mult_accept = ctrl_MULT & (div_state==IDLE).
//   - div_accept  = ctrl_DIV & ~ctrl_MULT & (div_state==IDLE) & mult pipe empty.
//   - MULT and DIV in the same cycle: MULT wins; stall=1.
//   - stall = (ctrl_MULT & ~mult_accept) | (ctrl_DIV & ~div_accept).
//     Rejected requests are not queued; decode holds and retries.
//   - Mult: MULT_STAGES-bit valid shift reg + tag shift reg, advancing every cycle.
//     Request accepted in cycle 0 -> resultRDY=1, result_sel=0, dest_out=tag in
//     cycle MULT_STAGES. Back-to-back accepts give back-to-back results.
//   - Divider FSM IDLE/RUN/DONE, down-counter cnt:
//     - IDLE: div_load = div_accept. On accept latch tag. If operand_b_zero,
//       go to DONE with exc=1; else go to RUN with cnt=DIV_CYCLES-1, exc=0.
//     - RUN: div_step_en=1; cnt decrements; cnt==0 -> DONE.
//     - DONE: resultRDY=1, result_sel=1, dest_out=div tag, data_exception=exc;
//       next state IDLE. New requests are accepted in the cycle after DONE.
//   - Div latency: accept in cycle 0 -> DONE in cycle DIV_CYCLES+1;
//     divide-by-zero -> DONE in cycle 1.
//   - Result collision is impossible by construction: div needs an empty mult pipe,
//     and mult is blocked while the divider is not IDLE.
//   - busy = |valid_pipe | (div_state != IDLE), registered.
//   - Reg outputs not described above are 0 whenever resultRDY=0.
// CONFIGURATION
//   MULTDIV_OVF_EN defined: on mult results data_exception = mult_overflow,
//     sampled in the cycle the result reaches the final stage.
//   MULTDIV_OVF_EN undefined: mult_overflow is ignored; mult results always have
//     data_exception=0. Only divide-by-zero raises an exception.
// TESTING
//   - Reset: assert reset mid-div (RUN, cnt=10) -> all outputs 0 immediately; no
//     resultRDY for 40 cycles after release.
//   - Mult pipeline: MULT on 3 consecutive cycles, tags 1,2,3 -> resultRDY in cycles
//     4,5,6, dest_out 1,2,3, result_sel=0, stall=0 throughout.
//   - Div: DIV tag 7, b!=0 in cycle 0 -> div_load=1 in cycle 0; div_step_en in
//     cycles 1..32; resultRDY, sel=1, dest=7, exc=0 in cycle 33; busy=0 in cycle 34.
//   - Div by zero: DIV with operand_b_zero=1, tag 9 -> resultRDY, exc=1, dest=9 in
//     cycle 1; div_step_en never asserted.
//   - Conflicts: MULT+DIV same cycle -> mult accepted, stall=1. DIV one cycle after
//     a MULT -> stall=1 until pipe empty. MULT during RUN -> stall=1.
//   - Overflow: with MULTDIV_OVF_EN, MULT and mult_overflow=1 at final stage ->
//     exc=1 in cycle 4. Without the macro, same stimulus -> exc=0.

Source files
------------

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Sequencer for the multdiv unit. It tracks ops through the
//                always-advancing multiplier latch stages, runs the iterative
//                divider FSM (IDLE/RUN/DONE), and drives one shared
//                result-ready / exception / select / tag interface.
//                Optional macro MULTDIV_OVF_EN: mult results carry
//                mult_overflow as their exception flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int MULT_STAGES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int TAG_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             operand_b_zero,
    input  logic             mult_overflow,
    input  logic [TAG_W-1:0] dest_in,
    output logic             stall,
    output logic             div_load,
    output logic             div_step_en,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             result_sel,
    output logic [TAG_W-1:0] dest_out,
    output logic             busy
);

    localparam int              CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Divider state
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [TAG_W-1:0] div_tag;
    logic [TAG_W-1:0] div_tag_next;
    logic             div_exc;
    logic             div_exc_next;

    // Multiplier tracking pipe; index MULT_STAGES-1 is the final stage
    logic [MULT_STAGES-1:0]            valid_pipe;
    logic [MULT_STAGES-1:0]            valid_next;
    logic [MULT_STAGES-1:0][TAG_W-1:0] tag_pipe;
    logic [MULT_STAGES-1:0][TAG_W-1:0] tag_next;

    logic             div_idle;
    logic             pipe_empty;
    logic             mult_accept;
    logic             div_accept;
    logic             mult_ovf_flag;

    // Next values of the registered outputs
    logic             rdy_next;
    logic             exc_next;
    logic             sel_next;
    logic [TAG_W-1:0] dest_next;
    logic             step_next;
    logic             busy_next;

    assign div_idle    = (state == S_IDLE);
    assign pipe_empty  = ~(|valid_pipe);
    assign mult_accept = ctrl_MULT & div_idle;
    // MULT has priority; a divide also waits for the mult pipe to drain so the
    // two result streams can never collide on the shared interface.
    assign div_accept  = ctrl_DIV & ~ctrl_MULT & div_idle & pipe_empty;

`ifdef MULTDIV_OVF_EN
    assign mult_ovf_flag = mult_overflow;
`else
    logic unused_mult_overflow;
    assign unused_mult_overflow = mult_overflow;
    assign mult_ovf_flag        = 1'b0;
`endif

    // Multiplier pipe shift: new entry at stage 0, everything else moves up
    always_comb begin
        valid_next    = '0;
        tag_next      = '0;
        valid_next[0] = mult_accept;
        tag_next[0]   = dest_in;
        for (int i = 1; i < MULT_STAGES; i++) begin
            valid_next[i] = valid_pipe[i-1];
            tag_next[i]   = tag_pipe[i-1];
        end
    end

    // State register: divider FSM, counter, latched div tag/exception, mult pipe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div_tag    <= '0;
            div_exc    <= 1'b0;
            valid_pipe <= '0;
            tag_pipe   <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            div_tag    <= div_tag_next;
            div_exc    <= div_exc_next;
            valid_pipe <= valid_next;
            tag_pipe   <= tag_next;
        end
    end

    // Next-state logic for the divider FSM and its down-counter
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        div_tag_next = div_tag;
        div_exc_next = div_exc;
        case (state)
            S_IDLE: begin
                if (div_accept) begin
                    div_tag_next = dest_in;
                    if (operand_b_zero) begin
                        // Divide-by-zero skips iteration and reports at once
                        state_next   = S_DONE;
                        div_exc_next = 1'b1;
                    end else begin
                        state_next   = S_RUN;
                        cnt_next     = CNT_LOAD;
                        div_exc_next = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: combinational handshakes plus next values of registered outputs
    always_comb begin
        stall     = (ctrl_MULT & ~mult_accept) | (ctrl_DIV & ~div_accept);
        div_load  = div_accept;
        step_next = (state_next == S_RUN);
        busy_next = (|valid_next) | (state_next != S_IDLE);
        rdy_next  = 1'b0;
        exc_next  = 1'b0;
        sel_next  = 1'b0;
        dest_next = '0;
        if (state_next == S_DONE) begin
            rdy_next  = 1'b1;
            sel_next  = 1'b1;
            exc_next  = div_exc_next;
            dest_next = div_tag_next;
        end else if (valid_next[MULT_STAGES-1]) begin
            rdy_next  = 1'b1;
            exc_next  = mult_ovf_flag;
            dest_next = tag_next[MULT_STAGES-1];
        end
    end

    // Registered outputs to writeback; all zero outside a result cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_step_en    <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            result_sel     <= 1'b0;
            dest_out       <= '0;
            busy           <= 1'b0;
        end else begin
            div_step_en    <= step_next;
            data_resultRDY <= rdy_next;
            data_exception <= exc_next;
            result_sel     <= sel_next;
            dest_out       <= dest_next;
            busy           <= busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Self-checking bench for multdiv_ctrl. A cycle-indexed
//                reference model predicts accepts, stalls and result slots
//                from the latency rules; directed scenarios are followed by
//                a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int MS = 4;
    localparam int DC = 32;
    localparam int TW = 5;
    localparam int N  = 4096;

    logic          clock          = 1'b0;
    logic          reset          = 1'b1;
    logic          ctrl_MULT      = 1'b0;
    logic          ctrl_DIV       = 1'b0;
    logic          operand_b_zero = 1'b0;
    logic          mult_overflow  = 1'b0;
    logic [TW-1:0] dest_in        = '0;
    logic          stall;
    logic          div_load;
    logic          div_step_en;
    logic          data_resultRDY;
    logic          data_exception;
    logic          result_sel;
    logic [TW-1:0] dest_out;
    logic          busy;

    multdiv_ctrl #(.MULT_STAGES(MS), .DIV_CYCLES(DC), .TAG_W(TW)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .operand_b_zero (operand_b_zero),
        .mult_overflow  (mult_overflow),
        .dest_in        (dest_in),
        .stall          (stall),
        .div_load       (div_load),
        .div_step_en    (div_step_en),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .result_sel     (result_sel),
        .dest_out       (dest_out),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: cycle numbers of the last events plus a result calendar
    int last_mult;
    int div_acc;
    int div_done;
    bit div_bz;
    bit e_rdy  [N];
    bit e_sel  [N];
    bit e_dexc [N];
    int e_tag  [N];
    bit ovh    [N];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", name, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            e_rdy[i]  = 1'b0;
            e_sel[i]  = 1'b0;
            e_dexc[i] = 1'b0;
            e_tag[i]  = 0;
            ovh[i]    = 1'b0;
        end
        last_mult = -1000;
        div_acc   = -1000;
        div_done  = -1000;
        div_bz    = 1'b0;
    endtask

    // One clock cycle: drive, predict, check mid-cycle, advance model
    task automatic step(input bit m, input bit d, input bit bz,
                        input logic [TW-1:0] tag, input bit ov);
        bit div_idle;
        bit empty;
        bit ma;
        bit da;
        bit ex_exc;
        bit ex_step;
        bit ex_busy;
        ctrl_MULT      = m;
        ctrl_DIV       = d;
        operand_b_zero = bz;
        dest_in        = tag;
        mult_overflow  = ov;
        ovh[cyc]       = ov;

        div_idle = (cyc > div_done);
        empty    = ((last_mult + MS) < cyc);
        ma       = m && div_idle;
        da       = d && !m && div_idle && empty;
        ex_step  = (cyc > div_acc) && (cyc <= div_acc + DC) && !div_bz;
        ex_busy  = ((cyc - last_mult) >= 1 && (cyc - last_mult) <= MS) ||
                   (cyc > div_acc && cyc <= div_done);
        if (e_rdy[cyc] && !e_sel[cyc]) begin
`ifdef MULTDIV_OVF_EN
            ex_exc = ovh[cyc-1];
`else
            ex_exc = 1'b0;
`endif
        end else begin
            ex_exc = e_dexc[cyc];
        end

        @(negedge clock);
        chk("stall",          32'(stall),          32'((m && !ma) || (d && !da)));
        chk("div_load",       32'(div_load),       32'(da));
        chk("div_step_en",    32'(div_step_en),    32'(ex_step));
        chk("data_resultRDY", 32'(data_resultRDY), 32'(e_rdy[cyc]));
        chk("result_sel",     32'(result_sel),     32'(e_sel[cyc]));
        chk("data_exception", 32'(data_exception), 32'(ex_exc));
        chk("dest_out",       32'(dest_out),       32'(e_tag[cyc]));
        chk("busy",           32'(busy),           32'(ex_busy));

        if (ma) begin
            last_mult        = cyc;
            e_rdy[cyc + MS]  = 1'b1;
            e_sel[cyc + MS]  = 1'b0;
            e_tag[cyc + MS]  = int'(tag);
        end
        if (da) begin
            div_acc          = cyc;
            div_bz           = bz;
            div_done         = bz ? cyc + 1 : cyc + DC + 1;
            e_rdy[div_done]  = 1'b1;
            e_sel[div_done]  = 1'b1;
            e_dexc[div_done] = bz;
            e_tag[div_done]  = int'(tag);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_stall"},       32'(stall),          32'd0);
        chk({pfx, "_div_load"},    32'(div_load),       32'd0);
        chk({pfx, "_step_en"},     32'(div_step_en),    32'd0);
        chk({pfx, "_resultRDY"},   32'(data_resultRDY), 32'd0);
        chk({pfx, "_exception"},   32'(data_exception), 32'd0);
        chk({pfx, "_result_sel"},  32'(result_sel),     32'd0);
        chk({pfx, "_dest_out"},    32'(dest_out),       32'd0);
        chk({pfx, "_busy"},        32'(busy),           32'd0);
    endtask

    initial begin
        model_clear();
        // Power-on reset
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("por");
        reset = 1'b0;
        cyc   = 0;

        // Three back-to-back mults, tags 1,2,3
        step(1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd3, 1'b0);
        idle(6);

        // Normal divide, tag 7
        step(1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
        idle(35);

        // Divide by zero, tag 9
        step(1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        idle(3);

        // MULT and DIV together, then DIV held while the mult pipe drains
        step(1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 5'd12, 1'b0);
        idle(35);

        // MULT attempted while the divider is running
        step(1'b0, 1'b1, 1'b0, 5'd20, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 5'd21, 1'b0);
        idle(35);

        // Overflow flag around the final mult stage
        step(1'b1, 1'b0, 1'b0, 5'd5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        idle(3);

        // Reset in the middle of a divide (counter at 10)
        step(1'b0, 1'b1, 1'b0, 5'd11, 1'b0);
        idle(21);
        ctrl_MULT      = 1'b0;
        ctrl_DIV       = 1'b0;
        operand_b_zero = 1'b0;
        mult_overflow  = 1'b0;
        dest_in        = '0;
        reset          = 1'b1;
        #1;
        check_all_zero("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        cyc++;
        idle(40);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 3) == 0, TW'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
